stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised, registered N:1 streaming multiplexer; next generation of the team's 8:1 enable-gated mux.
- Adds valid/ready handshakes on every channel, a one-beat output register, and a runtime mode select: fixed channel select or round-robin arbitration.
- Sits between multiple producer streams and a single shared consumer, e.g. a shared UART TX or display bus.

Parameters:
N_CH, 8, number of input channels (2..16, need not be a power of 2)
WIDTH, 8, data bits per channel
SEL_W, $clog2(N_CH), select/channel-index width (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = accept new beats; 0 = accept none
mode  input  1  0 = fixed select, 1 = round-robin
select  input  SEL_W  channel index used when mode=0
in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N_CH  per-channel valid
in_ready  output  N_CH  per-channel ready (combinational)
out_data  output  WIDTH  registered output beat
out_valid  output  1  registered output valid
out_ready  input  1  consumer ready
out_ch  output  SEL_W  index of the channel that supplied out_data

Behaviour:
- Reset (async assert, sync to clk on release): out_valid=0, out_data=0, out_ch=0, round-robin pointer rr_ptr=0.
- Output register is the only storage, one beat deep. can_load = ~out_valid | out_ready.
- Grant (combinational, one channel or none):
  - mode=0: grant = select if select < N_CH and in_valid[select]; else none. select >= N_CH never grants.
  - mode=1: first i with in_valid[i], searching rr_ptr, rr_ptr+1, … wrapping modulo N_CH; none if no valid.
- in_ready[i] = enable & can_load & (grant == i); at most one in_ready bit high per cycle. in_ready is not a function of in_valid[i] for the selected channel in mode=0, except through grant.
- Transfer on channel g when in_valid[g] & in_ready[g]. Next edge: out_data <= channel g data, out_ch <= g, out_valid <= 1.
- Latency: one cycle from input transfer to out_valid.
- Throughput: one beat per cycle while out_ready stays high.
- Output transfer when out_valid & out_ready:
  - With no simultaneous input transfer: out_valid <= 0.
  - With a simultaneous input transfer: register reloads; out_valid stays 1.
- Stall: while out_valid=1 and out_ready=0, out_data and out_ch hold and all in_ready are 0.
- rr_ptr updates only on an input transfer in mode=1: rr_ptr <= (g == N_CH-1) ? 0 : g+1. It holds in mode=0 and when there is no transfer.
- enable=0 blocks new transfers only. A buffered beat still drains normally; out_data holds its last value and is not forced to 0.
- mode or select changes take effect on the next grant. A buffered beat is unaffected. rr_ptr is retained across mode switches.
- Reset asserted mid-stream drops any buffered beat immediately: out_valid=0 asynchronously.
- No combinational path from out_ready to out_data or out_valid. A path from out_ready to in_ready is permitted.

Test Plan:
- Reset, then mode=0, select=3, enable=1, in_valid=8'hFF, ch3 data=8'hA5, out_ready=1 -> in_ready=8'h08. Next cycle: out_valid=1, out_data=8'hA5, out_ch=3. Continuous beats every cycle.
- mode=1, all 8 channels valid with data=index, out_ready=1 for 10 cycles -> out_ch sequence 0,1,2,…,7,0,1 and rr_ptr wraps 7->0.
- mode=1, only ch2 and ch6 valid, rr_ptr=3 -> grant ch6, then ch2, then ch6 (skip-ahead and wrap).
- Backpressure: out_ready=0 for 3 cycles with a beat buffered -> out_data and out_ch stable, in_ready=0. Raise out_ready -> the next beat loads in the same cycle the buffered beat drains, with no bubble.
- enable=0 with a beat buffered and out_ready=1 -> beat drains, out_valid falls to 0, no in_ready. Also with N_CH=6: mode=0, select=7 -> no grant, out_valid stays 0.
- Assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 without waiting for a clock edge. After release, mode=1 arbitration restarts at ch0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N:1 stream mux with fixed-select or round-robin grant
module stream_mux_rr #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      select,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
);
    localparam int P = 1 << SEL_W;
    logic [SEL_W-1:0] rr_ptr, gnt;
    logic             gnt_v, can_load, xfer;
    logic [P-1:0]     vpad;
    assign vpad     = P'(in_valid);
    assign can_load = ~out_valid | out_ready;
    assign in_ready = (enable & can_load & gnt_v) ? N_CH'(1) << gnt : '0;
    assign xfer     = |(in_valid & in_ready);
    // grant: fixed select, or first valid channel at or after rr_ptr (descending scan so the nearest wins)
    always_comb begin
        gnt_v = 1'b0;
        gnt   = '0;
        if (mode) begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                if (vpad[SEL_W'((int'(rr_ptr) + k) % N_CH)]) begin
                    gnt_v = 1'b1;
                    gnt   = SEL_W'((int'(rr_ptr) + k) % N_CH);
                end
            end
        end else if (int'(select) < N_CH && vpad[select]) begin
            gnt_v = 1'b1;
            gnt   = select;
        end
    end
    // one-beat output register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt*WIDTH +: WIDTH];
            out_ch    <= gnt;
            if (mode) rr_ptr <= (gnt == SEL_W'(N_CH - 1)) ? '0 : gnt + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: scoreboard bench for stream_mux_rr (8-channel main instance, 6-channel side instance)
module tb_stream_mux_rr;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [2:0]  select = 3'd0;
    logic [7:0]  d [8];
    logic [63:0] in_data;
    logic [7:0]  in_valid = 8'h00;
    logic [7:0]  in_ready, out_data;
    logic        out_valid;
    logic [2:0]  out_ch;
    logic [5:0]  in_ready6;
    logic [7:0]  out_data6;
    logic        out_valid6;
    logic [2:0]  out_ch6;
    int          n_chk = 0, n_err = 0;
    logic [11:0] sb [$];
    logic        m_valid = 1'b0;
    logic [2:0]  m_ptr = 3'd0;
    logic [7:0]  last_data = 8'h00;

    always #5 clk = ~clk;

    always_comb for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = d[i];

    stream_mux_rr #(.N_CH(8), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .select(select),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    stream_mux_rr #(.N_CH(6), .WIDTH(8)) dut6 (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .select(select),
        .in_data(in_data[47:0]), .in_valid(in_valid[5:0]), .in_ready(in_ready6),
        .out_data(out_data6), .out_valid(out_valid6), .out_ready(out_ready), .out_ch(out_ch6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock of the reference model: check at negedge, push/pop scoreboard, advance state after posedge
    task automatic tick();
        logic       can, gv, x, nv;
        logic [2:0] g, idx, np;
        logic [7:0] er;
        logic [11:0] h;
        @(negedge clk);
        can = !m_valid || out_ready;
        gv  = 1'b0;
        g   = 3'd0;
        if (mode) begin
            for (int k = 7; k >= 0; k--) begin
                idx = m_ptr + 3'(k);
                if (in_valid[idx]) begin gv = 1'b1; g = idx; end
            end
        end else if (in_valid[select]) begin
            gv = 1'b1;
            g  = select;
        end
        x  = enable && can && gv;
        er = x ? 8'(1) << g : 8'h00;
        check("in_ready", in_ready, er);
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("sb_depth", sb.size(), 1);
            h = sb[0];
            check("out_data", out_data, h[7:0]);
            check("out_ch", out_ch, h[10:8]);
            if (out_ready) begin
                last_data = h[7:0];
                void'(sb.pop_front());
            end
        end
        if (x) sb.push_back({1'b0, g, d[g]});
        nv = x ? 1'b1 : (out_ready ? 1'b0 : m_valid);
        np = (x && mode) ? g + 3'd1 : m_ptr;
        @(posedge clk);
        #1;
        m_valid = nv;
        m_ptr   = np;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) d[i] = 8'(i);
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        // fixed select channel 3, continuous beats
        d[3] = 8'hA5;
        enable = 1'b1; mode = 1'b0; select = 3'd3; in_valid = 8'hFF; out_ready = 1'b1;
        #1 check("sel3_in_ready", in_ready, 8'h08);
        repeat (4) tick();
        // round-robin over all channels, data = index
        d[3] = 8'h03;
        mode = 1'b1;
        repeat (10) tick();
        // move pointer to 3 via a lone ch2 beat, then ch2/ch6 alternate
        in_valid = 8'h04;
        tick();
        check("rr_ptr_is_3", m_ptr, 3);
        in_valid = 8'h44;
        repeat (3) tick();
        // backpressure with a beat buffered, then release with no bubble
        in_valid = 8'hFF;
        out_ready = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        repeat (2) tick();
        // enable low: buffered beat drains, no new accepts, data holds
        enable = 1'b0;
        repeat (3) tick();
        check("hold_data", out_data, last_data);
        // 6-channel instance: out-of-range select never grants
        enable = 1'b1; mode = 1'b0; select = 3'd7;
        repeat (3) begin
            tick();
            check("n6_in_ready", in_ready6, 0);
            check("n6_out_valid", out_valid6, 0);
        end
        select = 3'd5;
        d[5] = 8'h5C;
        #1 check("n6_sel5_ready", in_ready6, 6'h20);
        tick();
        check("n6_out_valid5", out_valid6, 1);
        check("n6_out_data5", out_data6, 8'h5C);
        check("n6_out_ch5", out_ch6, 5);
        // mid-stream async reset
        mode = 1'b1;
        repeat (3) tick();
        check("pre_rst_valid", out_valid, m_valid);
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_ch", out_ch, 0);
        sb.delete();
        m_valid = 1'b0;
        m_ptr   = 3'd0;
        rst = 1'b0;
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
